// File: rtl/btb_bht_assoc_if.sv
// btb_bht_assoc_if: fetch-side prediction, EX-side training and status signals of the branch target buffer
interface btb_bht_assoc_if;
    logic        flush_all;
    logic [31:0] pc_f;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_br;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] ex_pred_npc;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        busy;
    logic [31:0] stat_br;
    logic [31:0] stat_mispred;

    modport slave (
        input  flush_all, pc_f, upd_valid, upd_pc, upd_is_br, upd_taken, upd_target, ex_pred_npc,
        output pred_hit, pred_taken, pred_npc, mispredict, correct_pc, busy, stat_br, stat_mispred
    );

    modport master (
        output flush_all, pc_f, upd_valid, upd_pc, upd_is_br, upd_taken, upd_target, ex_pred_npc,
        input  pred_hit, pred_taken, pred_npc, mispredict, correct_pc, busy, stat_br, stat_mispred
    );
endinterface

// File: rtl/btb_bht_assoc.sv
// btb_bht_assoc: set-associative branch target buffer with per-entry saturating direction counters
module btb_bht_assoc #(
    parameter int SET_BITS = 6,
    parameter int WAYS = 2,
    parameter int CNT_BITS = 2,
    parameter logic [CNT_BITS-1:0] CNT_INIT = 2'b10
) (
    input logic clk,
    input logic rst,
    btb_bht_assoc_if.slave b
);
    localparam int SETS = 1 << SET_BITS;
    localparam int TW = 30 - SET_BITS;
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic {SWEEP, RUN} state_t;

    state_t state;
    logic [SET_BITS-1:0] sidx;
    logic [WAYS-1:0] valid [SETS];
    logic [TW-1:0] tag [SETS][WAYS];
    logic [31:0] target [SETS][WAYS];
    logic [CNT_BITS-1:0] cnt [SETS][WAYS];
    logic [WW-1:0] vptr [SETS];
    logic [31:0] sbr, smis, actual_npc;
    logic [SET_BITS-1:0] idx_f, idx_u;
    logic [TW-1:0] tag_f, tag_u;
    logic hit_f, hit_u, inv_u, run, wr;
    logic [WW-1:0] way_f, way_u, free_u, alloc_u;
    logic [CNT_BITS-1:0] c_u;

    assign idx_f = b.pc_f[SET_BITS+1:2];
    assign tag_f = b.pc_f[31:SET_BITS+2];
    assign idx_u = b.upd_pc[SET_BITS+1:2];
    assign tag_u = b.upd_pc[31:SET_BITS+2];

    // descending scan so the lowest matching / lowest free way is the one left standing
    always_comb begin
        hit_f = 1'b0;
        way_f = '0;
        hit_u = 1'b0;
        way_u = '0;
        inv_u = 1'b0;
        free_u = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx_f][w] && tag[idx_f][w] == tag_f) begin
                hit_f = 1'b1;
                way_f = WW'(w);
            end
            if (valid[idx_u][w] && tag[idx_u][w] == tag_u) begin
                hit_u = 1'b1;
                way_u = WW'(w);
            end
            if (!valid[idx_u][w]) begin
                inv_u = 1'b1;
                free_u = WW'(w);
            end
        end
    end

    assign run = state == RUN;
    assign wr = run && !rst && !b.flush_all && b.upd_valid;
    assign c_u = cnt[idx_u][way_u];
    assign alloc_u = inv_u ? free_u : vptr[idx_u];
    assign actual_npc = b.upd_is_br && b.upd_taken ? b.upd_target : b.upd_pc + 32'd4;

    assign b.busy = !run;
    assign b.pred_hit = run && hit_f;
    assign b.pred_taken = run && hit_f && cnt[idx_f][way_f][CNT_BITS-1];
    assign b.pred_npc = b.pred_taken ? target[idx_f][way_f] : b.pc_f + 32'd4;
    assign b.correct_pc = actual_npc;
    assign b.mispredict = b.upd_valid && actual_npc != b.ex_pred_npc;
    assign b.stat_br = sbr;
    assign b.stat_mispred = smis;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SWEEP;
            sidx <= '0;
            sbr <= '0;
            smis <= '0;
        end else begin
            if (b.flush_all) begin
                state <= SWEEP;
                sidx <= '0;
            end else if (!run) begin
                sidx <= sidx + 1'b1;
                if (&sidx) state <= RUN;
            end
            if (run) begin
                sbr <= sbr + {31'd0, ~&sbr && b.upd_valid && b.upd_is_br};
                smis <= smis + {31'd0, ~&smis && b.mispredict};
            end
        end
    end

    // entry storage carries no reset; the sweep is what invalidates it
    always_ff @(posedge clk) begin
        if (!run) begin
            valid[sidx] <= '0;
            vptr[sidx] <= '0;
        end else if (wr) begin
            if (hit_u && b.upd_is_br) begin
                cnt[idx_u][way_u] <= b.upd_taken ? (&c_u ? c_u : c_u + 1'b1) : (|c_u ? c_u - 1'b1 : c_u);
                if (b.upd_taken) target[idx_u][way_u] <= b.upd_target;
            end else if (hit_u) begin
                valid[idx_u][way_u] <= 1'b0;
            end else if (b.upd_is_br && b.upd_taken) begin
                valid[idx_u][alloc_u] <= 1'b1;
                tag[idx_u][alloc_u] <= tag_u;
                target[idx_u][alloc_u] <= b.upd_target;
                cnt[idx_u][alloc_u] <= CNT_INIT;
                if (!inv_u) vptr[idx_u] <= WAYS > 1 ? vptr[idx_u] + 1'b1 : '0;
            end
        end
    end
endmodule
